// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: opcodes, bus/register codes,
// ALU operations, FSM states and the EXEC-cycle transfer decode.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDM  = 4'h1;
  localparam logic [3:0] OP_STM  = 4'h2;
  localparam logic [3:0] OP_LDR  = 4'h3;
  localparam logic [3:0] OP_STR  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Register codes shared by wr_sel and rd_sel.
  localparam logic [3:0] SEL_NONE = 4'd0;
  localparam logic [3:0] SEL_PC   = 4'd1;
  localparam logic [3:0] SEL_DR   = 4'd2;
  localparam logic [3:0] SEL_R1   = 4'd3;
  localparam logic [3:0] SEL_R2   = 4'd4;
  localparam logic [3:0] SEL_R3   = 4'd5;
  localparam logic [3:0] SEL_R4   = 4'd6;
  localparam logic [3:0] SEL_R5   = 4'd7;
  localparam logic [3:0] SEL_TR   = 4'd8;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SHR  = 3'd2
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_EXEC,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic [3:0] wr_sel;
    logic [3:0] rd_sel;
    alu_op_e    alu_op;
  } xfer_t;

  function automatic logic reg_valid(input logic [3:0] r);
    return (r != SEL_NONE) && (r <= SEL_TR);
  endfunction

  function automatic logic uses_reg(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR) || (op == OP_ADD);
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_JMP) || (op == OP_HALT);
  endfunction

  function automatic logic instr_illegal(input logic [7:0] ir);
    return !op_legal(ir[7:4]) || (uses_reg(ir[7:4]) && !reg_valid(ir[3:0]));
  endfunction

  // Single register transfer performed in EXEC; illegal words decode as NOP.
  function automatic xfer_t exec_xfer(input logic [7:0] ir, input logic z);
    xfer_t x;
    x = '0;
    case (ir[7:4])
      OP_LDR:  begin x.wr_sel = ir[3:0]; x.rd_sel = SEL_DR;  end
      OP_STR:  begin x.wr_sel = SEL_DR;  x.rd_sel = ir[3:0]; end
      OP_ADD:  begin x.wr_sel = SEL_TR;  x.rd_sel = ir[3:0]; x.alu_op = ALU_ADD; end
      OP_SHR:  begin x.wr_sel = SEL_TR;  x.rd_sel = SEL_TR;  x.alu_op = ALU_SHR; end
      OP_JZ:   if (z) begin x.wr_sel = SEL_PC; x.rd_sel = SEL_DR; end
      OP_JMP:  begin x.wr_sel = SEL_PC;  x.rd_sel = SEL_DR;  end
      default: x = '0;
    endcase
    if (instr_illegal(ir)) x = '0;
    return x;
  endfunction

endpackage

// File: rtl/mem_handshake_timer.sv
// Memory handshake tracker: turns a held request plus mem_ready into an
// acknowledge, and flags a timeout after MEM_TIMEOUT non-ready cycles.
module mem_handshake_timer #(
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic mem_ready_i,
  output logic ack_o,
  output logic timeout_o
);

  localparam logic [TO_W-1:0] LAST_WAIT = TO_W'(MEM_TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign ack_o     = req_i && mem_ready_i;
  // A ready on the limit cycle suppresses the timeout.
  assign timeout_o = req_i && !mem_ready_i && (cnt_q == LAST_WAIT);

  always_comb begin
    // NOTE: default assigned first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (!req_i || mem_ready_i || timeout_o) cnt_d = '0;
    else                                    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/control_sequencer.sv
// Micro-sequencer: fetch/decode/execute FSM producing registered write-enable,
// bus-select, ALU and memory strobes for the down-sampler datapath.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int SEL_W       = 4,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       instr,
  input  logic             z_flag,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_load,
  output logic             pc_inc,
  output logic [SEL_W-1:0] wr_sel,
  output logic [SEL_W-1:0] rd_sel,
  output logic [2:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [7:0]       ir_q, ir_d;
  logic             err_q, err_d;
  logic             mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;
  logic [SEL_W-1:0] wr_sel_q, wr_sel_d;
  logic [SEL_W-1:0] rd_sel_q, rd_sel_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic       ack, timeout;
  logic [3:0] op;
  xfer_t      xfer;

  assign op   = ir_q[7:4];
  assign xfer = exec_xfer(ir_q, z_flag);

  mem_handshake_timer #(
    .TO_W        (TO_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (mem_rd_q | mem_wr_q),
    .mem_ready_i (mem_ready),
    .ack_o       (ack),
    .timeout_o   (timeout)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_HALT: if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (ack) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (instr_illegal(ir_q)) begin
          err_d   = 1'b1;
          state_d = ST_EXEC;
        end else if (op == OP_LDM || op == OP_STM) begin
          state_d = ST_MEM;
        end else if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_MEM: begin
        if (ack) begin
          state_d = ST_FETCH;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_EXEC: state_d = ST_FETCH;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so they are valid
  // for the whole of that state.
  always_comb begin
    mem_rd_d = (state_d == ST_FETCH) || (state_d == ST_MEM && op == OP_LDM);
    mem_wr_d = (state_d == ST_MEM && op == OP_STM);
    wr_sel_d = '0;
    rd_sel_d = '0;
    alu_op_d = ALU_PASS;
    if (state_d == ST_EXEC) begin
      wr_sel_d = SEL_W'(xfer.wr_sel);
      rd_sel_d = SEL_W'(xfer.rd_sel);
      alu_op_d = xfer.alu_op;
    end
    busy_d = (state_d != ST_IDLE) && (state_d != ST_HALT);
    done_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: IR is reset too, so decode never sees X after an abort.
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;
      err_q    <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      wr_sel_q <= '0;
      rd_sel_q <= '0;
      alu_op_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      err_q    <= err_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      alu_op_q <= alu_op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Completion strobes coincide with the mem_ready cycle: a registered
  // request qualified by ready, so they still drop with reset.
  assign ir_load = ack && (state_q == ST_FETCH);
  assign pc_inc  = ir_load;
  assign wr_sel  = (ack && mem_rd_q && state_q == ST_MEM) ? SEL_W'(SEL_DR) : wr_sel_q;

  assign mem_rd = mem_rd_q;
  assign mem_wr = mem_wr_q;
  assign rd_sel = rd_sel_q;
  assign alu_op = alu_op_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: hand-computed expectations checked
// one cycle at a time, 1-2 time units after each rising edge.
module tb_control_sequencer;

  logic       clk, rst_n, start, z_flag, mem_ready;
  logic [7:0] instr;
  logic       mem_rd, mem_wr, ir_load, pc_inc, busy, done, err;
  logic [3:0] wr_sel, rd_sel;
  logic [2:0] alu_op;

  int vectors    = 0;
  int miscompares = 0;

  control_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .instr     (instr),
    .z_flag    (z_flag),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .ir_load   (ir_load),
    .pc_inc    (pc_inc),
    .wr_sel    (wr_sel),
    .rd_sel    (rd_sel),
    .alu_op    (alu_op),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic held;
    rst_n = 1'b0; start = 1'b0; instr = 8'h00; z_flag = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_wr_sel", wr_sel, 0);
    check("rst_busy",   busy,   0);
    check("rst_done",   done,   0);
    check("rst_err",    err,    0);
    rst_n = 1'b1;

    // ADD R1 with zero wait: EXEC strobes on the third cycle after start.
    start = 1'b1; next(); start = 1'b0;
    instr = 8'h53; mem_ready = 1'b1; #1;
    check("add_c1_mem_rd",  mem_rd,  1);
    check("add_c1_ir_load", ir_load, 1);
    check("add_c1_pc_inc",  pc_inc,  1);
    check("add_c1_busy",    busy,    1);
    next(); mem_ready = 1'b0; #1;
    check("add_c2_quiet", {mem_rd, ir_load, wr_sel}, 0);
    next();
    check("add_c3_wr_sel", wr_sel, 8);
    check("add_c3_rd_sel", rd_sel, 3);
    check("add_c3_alu_op", alu_op, 1);

    // LDM with four wait cycles in MEM.
    next(); instr = 8'h10; mem_ready = 1'b1; #1;
    check("ldm_ir_load", ir_load, 1);
    next(); mem_ready = 1'b0; #1;
    check("ldm_decode_mem_rd", mem_rd, 0);
    next();
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) mem_ready = 1'b1;
      #1;
      held &= mem_rd;
      check($sformatf("ldm_wr_sel_%0d", i), wr_sel, (i == 4) ? 2 : 0);
      next();
    end
    mem_ready = 1'b0; #1;
    check("ldm_mem_rd_held5", held, 1);
    check("ldm_refetch_mem_rd", mem_rd, 1);
    check("ldm_refetch_wr_sel", wr_sel, 0);

    // JZ not taken, then taken.
    instr = 8'h70; z_flag = 1'b0; mem_ready = 1'b1;
    next(); mem_ready = 1'b0;
    next();
    check("jz0_wr_sel", wr_sel, 0);
    check("jz0_rd_sel", rd_sel, 0);
    next(); z_flag = 1'b1; mem_ready = 1'b1;
    next(); mem_ready = 1'b0;
    next();
    check("jz1_wr_sel", wr_sel, 1);
    check("jz1_rd_sel", rd_sel, 2);

    // SHR and STR R3.
    next(); z_flag = 1'b0; instr = 8'h60; mem_ready = 1'b1;
    next(); mem_ready = 1'b0;
    next();
    check("shr_wr_sel", wr_sel, 8);
    check("shr_rd_sel", rd_sel, 8);
    check("shr_alu_op", alu_op, 2);
    next(); instr = 8'h45; mem_ready = 1'b1;
    next(); mem_ready = 1'b0;
    next();
    check("str_wr_sel", wr_sel, 2);
    check("str_rd_sel", rd_sel, 5);
    check("str_alu_op", alu_op, 0);

    // Fetch withheld for 255 cycles: timeout into HALT.
    next();
    check("to_err_before", err, 0);
    held = 1'b1;
    for (int i = 0; i < 255; i++) begin
      held &= mem_rd;
      next();
    end
    check("to_mem_rd_held255", held, 1);
    check("to_mem_rd", mem_rd, 0);
    check("to_err",    err,    1);
    check("to_done",   done,   1);
    check("to_busy",   busy,   0);

    // start in HALT resumes fetching with err kept.
    start = 1'b1; next(); start = 1'b0;
    check("res_mem_rd", mem_rd, 1);
    check("res_done",   done,   0);
    check("res_err",    err,    1);

    // Ready arriving on the limit cycle wins over the timeout.
    for (int i = 0; i < 254; i++) next();
    instr = 8'h00; mem_ready = 1'b1; #1;
    check("lim_ir_load", ir_load, 1);
    next(); mem_ready = 1'b0; #1;
    check("lim_busy", busy, 1);
    check("lim_done", done, 0);
    next(); next();
    check("pre_rst_mem_rd", mem_rd, 1);

    // Reset mid-FETCH drops everything at once.
    mem_ready = 1'b1; rst_n = 1'b0; #1;
    check("arst_mem_rd",  mem_rd,  0);
    check("arst_ir_load", ir_load, 0);
    check("arst_busy",    busy,    0);
    check("arst_err",     err,     0);
    mem_ready = 1'b0;
    next(); rst_n = 1'b1;
    next();
    check("arst_idle_busy", busy, 0);

    // Illegal register field, then illegal opcode.
    start = 1'b1; next(); start = 1'b0;
    instr = 8'h39; mem_ready = 1'b1;
    next(); mem_ready = 1'b0; #1;
    check("ill_decode_err", err, 0);
    next();
    check("ill_err",    err,    1);
    check("ill_wr_sel", wr_sel, 0);
    next();
    check("ill_refetch_mem_rd", mem_rd, 1);
    instr = 8'hA0; mem_ready = 1'b1;
    next(); mem_ready = 1'b0;
    next();
    check("ill2_wr_sel", wr_sel, 0);
    check("ill2_rd_sel", rd_sel, 0);

    // HALT opcode.
    next(); instr = 8'hF0; mem_ready = 1'b1;
    next(); mem_ready = 1'b0;
    next();
    check("halt_done",   done,   1);
    check("halt_busy",   busy,   0);
    check("halt_mem_rd", mem_rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
